// File: rtl/i2c_target_mem.sv
// -----------------------------------------------------------------------------
// i2c_target_mem
//   I2C target (responder) backed by a small on-chip byte memory. It answers a
//   single fixed 7-bit device address and keeps an auto-incrementing word
//   pointer. The first data byte of a write loads the pointer, and each later
//   byte is stored at mem[ptr]. A read streams mem[ptr], mem[ptr+1], ... until
//   the controller NACKs. SDA is driven open-drain only: sda_oe pulls the line
//   low, and the enclosing top level owns the pad, the tristate and the pull-up.
//
// Ports
//   clk        system clock, must run at least 16x the SCL frequency
//   rst        asynchronous, active-high reset
//   scl_i      SCL pin level, asynchronous to clk
//   sda_i      SDA pin level, asynchronous to clk
//   sda_oe     1 = pull SDA low, 0 = release the line
//   busy       high whenever the FSM is outside IDLE
//   wr_strobe  one-clk pulse each time a memory byte is written
//   wr_addr    address of the last written byte
//   wr_data    value of the last written byte
// -----------------------------------------------------------------------------
module i2c_target_mem #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         AW       = 7,
  parameter int         DEPTH    = 128,
  parameter logic [7:0] FILL     = 8'h91
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_DEVADDR = 4'd1;
  localparam logic [3:0] ST_DACK    = 4'd2;  // 9th clock of the address byte
  localparam logic [3:0] ST_REGADDR = 4'd3;
  localparam logic [3:0] ST_WACK    = 4'd4;  // 9th clock of a pointer/data byte
  localparam logic [3:0] ST_WDATA   = 4'd5;
  localparam logic [3:0] ST_RDATA   = 4'd6;
  localparam logic [3:0] ST_RACK    = 4'd7;  // controller ACK/NACK after a read byte
  localparam logic [3:0] ST_WAITP   = 4'd8;

  // Pin synchronizers (s1, s2) plus one history flop (h) for edge detection.
  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_h_q, scl_h_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_h_q, sda_h_d;

  logic [3:0]    state_q,     state_d;
  logic [2:0]    bit_cnt_q,   bit_cnt_d;
  logic          got_byte_q,  got_byte_d;   // 8 bits shifted, waiting for the 8th fall
  logic [7:0]    shreg_q,     shreg_d;
  logic          rw_q,        rw_d;
  logic          nack_q,      nack_d;
  logic [AW-1:0] ptr_q,       ptr_d;
  logic          oe_load_q,   oe_load_d;    // apply oe_next one clk after a detected SCL fall
  logic          oe_next_q,   oe_next_d;
  logic          sda_oe_q,    sda_oe_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q,   wr_addr_d;
  logic [7:0]    wr_data_q,   wr_data_d;

  logic [7:0]    mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [7:0]    mem_wd;
  logic [7:0]    mem_rd;

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  =  scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q &  scl_h_q;
  // START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  assign start_det =  scl_s2_q &  scl_h_q &  sda_h_q & ~sda_s2_q;
  assign stop_det  =  scl_s2_q &  scl_h_q & ~sda_h_q &  sda_s2_q;

  assign mem_rd = mem_q[ptr_q];

  // NOTE: every variable assigned in this block receives a default value first,
  // so no path through the case/if tree can infer a latch.
  always_comb begin
    scl_s1_d    = scl_i;
    scl_s2_d    = scl_s1_q;
    scl_h_d     = scl_s2_q;
    sda_s1_d    = sda_i;
    sda_s2_d    = sda_s1_q;
    sda_h_d     = sda_s2_q;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    got_byte_d  = got_byte_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    nack_d      = nack_q;
    ptr_d       = ptr_q;
    oe_load_d   = 1'b0;
    oe_next_d   = oe_next_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    mem_wa      = ptr_q;
    mem_wd      = shreg_q;

    if (oe_load_q) begin
      sda_oe_d = oe_next_q;
    end

    if (start_det) begin
      // A START or repeated START outranks any bit activity in the same clk and
      // discards a partially shifted byte.
      state_d    = ST_DEVADDR;
      bit_cnt_d  = 3'd0;
      got_byte_d = 1'b0;
      sda_oe_d   = 1'b0;
      oe_load_d  = 1'b0;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      got_byte_d = 1'b0;
      sda_oe_d   = 1'b0;
      oe_load_d  = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_DEVADDR, ST_REGADDR, ST_WDATA: begin
          shreg_d   = {shreg_q[6:0], sda_s2_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) got_byte_d = 1'b1;
        end
        ST_RDATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) got_byte_d = 1'b1;
        end
        ST_RACK: nack_d = sda_s2_q;
        default: ;
      endcase
    end else if (scl_fall) begin
      // SDA is only ever changed one clk after a detected SCL fall, so it is
      // stable for the whole SCL high phase. Release unless a state claims it.
      oe_load_d = 1'b1;
      oe_next_d = 1'b0;
      case (state_q)
        ST_DEVADDR: begin
          if (got_byte_q) begin
            got_byte_d = 1'b0;
            if (shreg_q[7:1] == DEV_ADDR) begin
              state_d   = ST_DACK;
              rw_d      = shreg_q[0];
              oe_next_d = 1'b1;
            end else begin
              state_d   = ST_IDLE;
            end
          end
        end
        ST_DACK: begin
          if (rw_q) begin
            state_d   = ST_RDATA;
            shreg_d   = mem_rd;
            oe_next_d = ~mem_rd[7];
          end else begin
            state_d   = ST_REGADDR;
          end
        end
        ST_REGADDR: begin
          if (got_byte_q) begin
            got_byte_d = 1'b0;
            ptr_d      = shreg_q[AW-1:0];
            state_d    = ST_WACK;
            oe_next_d  = 1'b1;
          end
        end
        ST_WACK: state_d = ST_WDATA;
        ST_WDATA: begin
          if (got_byte_q) begin
            got_byte_d  = 1'b0;
            mem_we      = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = ptr_q;
            wr_data_d   = shreg_q;
            ptr_d       = ptr_q + AW'(1);
            state_d     = ST_WACK;
            oe_next_d   = 1'b1;
          end
        end
        ST_RDATA: begin
          if (got_byte_q) begin
            got_byte_d = 1'b0;
            ptr_d      = ptr_q + AW'(1);
            state_d    = ST_RACK;
          end else begin
            shreg_d    = {shreg_q[6:0], 1'b0};
            oe_next_d  = ~shreg_q[6];
          end
        end
        ST_RACK: begin
          if (nack_q) begin
            state_d   = ST_WAITP;
          end else begin
            // ptr already advanced past the byte just sent; a byte written
            // moments earlier is visible here because mem_q is read directly.
            state_d   = ST_RDATA;
            shreg_d   = mem_rd;
            oe_next_d = ~mem_rd[7];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // arithmetic happens in the combinational block above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_h_q     <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_h_q     <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      got_byte_q  <= 1'b0;
      shreg_q     <= 8'h00;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      ptr_q       <= '0;
      oe_load_q   <= 1'b0;
      oe_next_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      scl_s1_q    <= scl_s1_d;
      scl_s2_q    <= scl_s2_d;
      scl_h_q     <= scl_h_d;
      sda_s1_q    <= sda_s1_d;
      sda_s2_q    <= sda_s2_d;
      sda_h_q     <= sda_h_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      got_byte_q  <= got_byte_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      nack_q      <= nack_d;
      ptr_q       <= ptr_d;
      oe_load_q   <= oe_load_d;
      oe_next_q   <= oe_next_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // NOTE: the memory is built from resettable flops on purpose, because every
  // byte must read back as FILL after reset. This rules out a RAM macro
  // without reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= FILL;
    end else if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = (state_q != ST_IDLE);
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
